superh16_wb_arbiter: RTL

- Consumer end of the execution-unit result interface. Each unit (int ALU, mul, load, ...) presents valid/result/dst_tag/rob_idx/exception, one result per cycle.
- Buffers each source in a small per-source FIFO and arbitrates round-robin onto NUM_WB registered writeback ports.
- The writeback ports drive PRF writes, ROB completion and wakeup broadcast.
- Returns a per-source stall so issue can throttle fixed-latency units.

---
 rtl/superh16_pkg.sv | 23 ++
 rtl/superh16_wb_fifo.sv | 77 +++++++
 rtl/superh16_wb_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/superh16_pkg.sv
// Shared types for the SuperH16 writeback path.
//   wb_entry_t : one execution-unit result as buffered and written back
//   idx_bits() : index width for an N-entry selector, never zero
package superh16_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned PHYS_REG_BITS = 7;
    localparam int unsigned ROB_IDX_BITS  = 6;
    localparam int unsigned EXC_CODE_BITS = 8;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [PHYS_REG_BITS-1:0] dst_tag;
        logic [ROB_IDX_BITS-1:0]  rob_idx;
        logic                     exception;
        logic [EXC_CODE_BITS-1:0] exception_code;
    } wb_entry_t;

    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/superh16_wb_fifo.sv
// Per-source result FIFO for the writeback arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : empty the FIFO; a push in the same cycle is discarded
//   push       : write push_entry (accepted when not full, or when full and popped)
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   empty      : no entries stored
//   count      : registered occupancy, 0..DEPTH
//   drop       : push rejected because the FIFO was full and not popped
module superh16_wb_fifo
    import superh16_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A full FIFO still accepts when its head leaves in the same cycle.
        do_push = push && !flush && ((count_q != FULL_CNT) || do_pop);
        drop    = push && !flush && !do_push;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/superh16_wb_arbiter.sv
// Writeback arbiter: buffers execution-unit results per source and grants up
// to NUM_WB FIFO heads per cycle, round-robin, onto registered writeback ports.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : drop all buffered results and clear the ports
//   src_*               : per-source result interface (valid, data, tag, ROB, exception)
//   src_stall           : per-source throttle, high when at most one slot is free
//   wb_*                : registered writeback ports (PRF write, ROB completion, wakeup)
//   wb_rf_we            : wb_valid masked by wb_exception
//   overflow_err        : sticky, a result was dropped on a full FIFO
module superh16_wb_arbiter
    import superh16_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned NUM_WB     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush,
    input  logic [NUM_SRC-1:0]                         src_valid,
    input  logic [NUM_SRC-1:0][XLEN-1:0]               src_result,
    input  logic [NUM_SRC-1:0][PHYS_REG_BITS-1:0]      src_dst_tag,
    input  logic [NUM_SRC-1:0][ROB_IDX_BITS-1:0]       src_rob_idx,
    input  logic [NUM_SRC-1:0]                         src_exception,
    input  logic [NUM_SRC-1:0][EXC_CODE_BITS-1:0]      src_exception_code,
    output logic [NUM_SRC-1:0]                         src_stall,
    output logic [NUM_WB-1:0]                          wb_valid,
    output logic [NUM_WB-1:0]                          wb_rf_we,
    output logic [NUM_WB-1:0][XLEN-1:0]                wb_result,
    output logic [NUM_WB-1:0][PHYS_REG_BITS-1:0]       wb_dst_tag,
    output logic [NUM_WB-1:0][ROB_IDX_BITS-1:0]        wb_rob_idx,
    output logic [NUM_WB-1:0]                          wb_exception,
    output logic [NUM_WB-1:0][EXC_CODE_BITS-1:0]       wb_exception_code,
    output logic                                       overflow_err
);

    localparam int unsigned SRC_W = idx_bits(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    // One spare slot absorbs the result already in flight from a 1-cycle unit.
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 1);

    wb_entry_t [NUM_SRC-1:0]            push_entry;
    wb_entry_t [NUM_SRC-1:0]            head;
    logic      [NUM_SRC-1:0]            fifo_empty;
    logic      [NUM_SRC-1:0]            grant;
    logic      [NUM_SRC-1:0]            drop;
    logic      [NUM_SRC-1:0][CNT_W-1:0] fifo_count;

    logic      [NUM_WB-1:0]             port_vld;
    logic      [NUM_WB-1:0][SRC_W-1:0]  port_src;
    logic      [SRC_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic      [SRC_W-1:0]              scan_idx, last_src;
    int unsigned                        n_grant;

    logic      [NUM_WB-1:0]             wb_valid_q, wb_valid_d;
    wb_entry_t [NUM_WB-1:0]             wb_entry_q, wb_entry_d;
    logic                               overflow_err_q;

    // ---------------------------------------------------------------------
    // Per-source FIFOs
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_entry[i] = '{
            result:         src_result[i],
            dst_tag:        src_dst_tag[i],
            rob_idx:        src_rob_idx[i],
            exception:      src_exception[i],
            exception_code: src_exception_code[i]
        };

        superh16_wb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .push       (src_valid[i]),
            .push_entry (push_entry[i]),
            .pop        (grant[i]),
            .head       (head[i]),
            .empty      (fifo_empty[i]),
            .count      (fifo_count[i]),
            .drop       (drop[i])
        );

        assign src_stall[i] = (fifo_count[i] >= STALL_CNT);
    end

    // ---------------------------------------------------------------------
    // Round-robin multi-grant: walk sources from rr_ptr, hand the k-th
    // non-empty head to port k until the ports run out.
    // ---------------------------------------------------------------------
    always_comb begin
        grant    = '0;
        port_vld = '0;
        port_src = '0;
        n_grant  = 0;
        scan_idx = '0;
        last_src = rr_ptr_q;

        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            scan_idx = SRC_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!fifo_empty[scan_idx] && (n_grant < NUM_WB)) begin
                grant[scan_idx] = 1'b1;
                for (int unsigned w = 0; w < NUM_WB; w++) begin
                    if (n_grant == w) begin
                        port_vld[w] = 1'b1;
                        port_src[w] = scan_idx;
                    end
                end
                n_grant  = n_grant + 1;
                last_src = scan_idx;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if ((|grant) && !flush) begin
            rr_ptr_d = (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + SRC_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Writeback port next-state: ungranted ports and flushes carry zeros.
    // ---------------------------------------------------------------------
    always_comb begin
        wb_valid_d = '0;
        wb_entry_d = '0;
        for (int unsigned w = 0; w < NUM_WB; w++) begin
            if (port_vld[w] && !flush) begin
                wb_valid_d[w] = 1'b1;
                wb_entry_d[w] = head[port_src[w]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            wb_valid_q     <= '0;
            wb_entry_q     <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            wb_valid_q     <= wb_valid_d;
            wb_entry_q     <= wb_entry_d;
            overflow_err_q <= overflow_err_q | (|drop);
        end
    end

    // ---------------------------------------------------------------------
    // Output unpacking
    // ---------------------------------------------------------------------
    for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
        assign wb_result[w]         = wb_entry_q[w].result;
        assign wb_dst_tag[w]        = wb_entry_q[w].dst_tag;
        assign wb_rob_idx[w]        = wb_entry_q[w].rob_idx;
        assign wb_exception[w]      = wb_entry_q[w].exception;
        assign wb_exception_code[w] = wb_entry_q[w].exception_code;
        assign wb_rf_we[w]          = wb_valid_q[w] & ~wb_entry_q[w].exception;
    end

    assign wb_valid     = wb_valid_q;
    assign overflow_err = overflow_err_q;

endmodule
